// File: rtl/gray_convert_pkg.sv
// +------------------------------------------------------------------+
// | Module   : gray_convert_pkg                                       |
// | Brief    : Shared constants, luma weights and FSM state encoding  |
// |            for the BMP grayscale conversion stage.                |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package gray_convert_pkg;

  // Image geometry and RAM bus widths
  localparam int BMP_HEADER_SIZE = 54;
  localparam int BMP_TOTAL_SIZE  = 68;
  localparam int ADDR_WIDTH      = 16;
  localparam int BYTE_WIDTH      = 8;

  // Luma weights in 1/256 units; they must add up to exactly 256
  localparam int W_R = 77;
  localparam int W_G = 150;
  localparam int W_B = 29;

  // Fixed-point scaling applied after the weighted sum
  localparam int LUMA_SHIFT = 8;
  localparam int ROUND_BIAS = 128;

  // Conversion FSM states
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RD_B = 4'd1,
    ST_RD_G = 4'd2,
    ST_RD_R = 4'd3,
    ST_CALC = 4'd4,
    ST_WR_B = 4'd5,
    ST_WR_G = 4'd6,
    ST_WR_R = 4'd7,
    ST_DONE = 4'd8
  } gray_state_t;

  // Number of complete B,G,R triplets between the header and the end of file
  function automatic int pixel_count(input int total_size, input int header_size);
    if (total_size - header_size < 3) begin
      return 0;
    end
    return (total_size - header_size) / 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_convert_luma.sv
// +------------------------------------------------------------------+
// | Module   : gray_convert_luma                                      |
// | Brief    : Combinational B,G,R -> Y luma calculator.              |
// |            Config macro GRAY_ROUND_EN: defined -> round half up,  |
// |            undefined -> truncate.                                 |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module gray_convert_luma
  import gray_convert_pkg::*;
#(
  parameter int DATA_W = BYTE_WIDTH
) (
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] y
);

  // One spare bit above weight*max so the rounding bias can never wrap
  localparam int SUM_W = DATA_W + LUMA_SHIFT + 1;

  logic [SUM_W-1:0] sum;

  // Weighted sum, optional rounding bias, then drop the fractional byte
  always_comb begin
    sum = SUM_W'(W_R) * SUM_W'(r)
        + SUM_W'(W_G) * SUM_W'(g)
        + SUM_W'(W_B) * SUM_W'(b);
`ifdef GRAY_ROUND_EN
    sum = sum + SUM_W'(ROUND_BIAS);
`else
    sum = sum + SUM_W'(0);
`endif
    y = DATA_W'(sum >> LUMA_SHIFT);
  end

endmodule

`default_nettype wire

// File: rtl/gray_convert.sv
// +------------------------------------------------------------------+
// | Module   : gray_convert                                           |
// | Brief    : Walks 24-bit BMP pixel data in the shared byte RAM,    |
// |            reads each B,G,R triplet and writes its luma back to   |
// |            all three bytes. Raises gray_done when finished.       |
// |            Config macro GRAY_ROUND_EN selects rounded luma (see   |
// |            gray_convert_luma); timing is identical either way.    |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module gray_convert
  import gray_convert_pkg::*;
#(
  parameter int HEADER_SIZE = BMP_HEADER_SIZE,
  parameter int TOTAL_SIZE  = BMP_TOTAL_SIZE,
  parameter int ADDR_W      = ADDR_WIDTH,
  parameter int DATA_W      = BYTE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic              RAM_ren,
  output logic              RAM_wen,
  output logic [DATA_W-1:0] RAM_D,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic              gray_done
);

  // Trailing bytes that do not form a full triplet are never visited, so the
  // walk ends on the last complete pixel rather than on the file end.
  localparam int PIXELS     = pixel_count(TOTAL_SIZE, HEADER_SIZE);
  localparam bit HAS_PIXELS = (PIXELS > 0);

  localparam logic [ADDR_W-1:0] FIRST_BASE = ADDR_W'(HEADER_SIZE);
  localparam logic [ADDR_W-1:0] LAST_BASE  =
    HAS_PIXELS ? ADDR_W'(HEADER_SIZE + 3 * (PIXELS - 1)) : FIRST_BASE;

  localparam logic [ADDR_W-1:0] OFS_G    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS_R    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(3);

  gray_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_sel;
  logic [DATA_W-1:0] luma_y;

  // Red arrives on RAM_Q during CALC; feed it straight in so Y is ready to
  // register on the CALC -> WR_B edge, and use the captured copy otherwise.
  always_comb begin
    r_sel = r_q;
    if (state == ST_CALC) begin
      r_sel = RAM_Q;
    end
  end

  gray_convert_luma #(
    .DATA_W (DATA_W)
  ) u_luma (
    .b (b_q),
    .g (g_q),
    .r (r_sel),
    .y (luma_y)
  );

  // Conversion FSM: bus outputs are registered together with the next state,
  // so each state presents its own strobe/address from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      base      <= FIRST_BASE;
      RAM_ren   <= 1'b0;
      RAM_wen   <= 1'b0;
      RAM_D     <= '0;
      RAM_addr  <= '0;
      gray_done <= 1'b0;
      b_q       <= '0;
      g_q       <= '0;
      r_q       <= '0;
    end else begin
      // Strobes are single-state pulses; only the states below raise them
      RAM_ren <= 1'b0;
      RAM_wen <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (HAS_PIXELS) begin
              state    <= ST_RD_B;
              RAM_ren  <= 1'b1;
              RAM_addr <= base;
            end else begin
              // Nothing to convert: finish without touching the RAM
              state     <= ST_DONE;
              gray_done <= 1'b1;
              RAM_addr  <= '0;
            end
          end
        end

        ST_RD_B: begin
          state    <= ST_RD_G;
          RAM_ren  <= 1'b1;
          RAM_addr <= base + OFS_G;
        end

        ST_RD_G: begin
          b_q      <= RAM_Q;
          state    <= ST_RD_R;
          RAM_ren  <= 1'b1;
          RAM_addr <= base + OFS_R;
        end

        ST_RD_R: begin
          g_q   <= RAM_Q;
          state <= ST_CALC;
        end

        ST_CALC: begin
          // Y is computed once here and held in RAM_D for all three writes
          r_q      <= RAM_Q;
          RAM_D    <= luma_y;
          state    <= ST_WR_B;
          RAM_wen  <= 1'b1;
          RAM_addr <= base;
        end

        ST_WR_B: begin
          state    <= ST_WR_G;
          RAM_wen  <= 1'b1;
          RAM_addr <= base + OFS_G;
        end

        ST_WR_G: begin
          state    <= ST_WR_R;
          RAM_wen  <= 1'b1;
          RAM_addr <= base + OFS_R;
        end

        ST_WR_R: begin
          if (base == LAST_BASE) begin
            state     <= ST_DONE;
            gray_done <= 1'b1;
            RAM_addr  <= '0;
          end else begin
            base     <= base + PIX_STEP;
            state    <= ST_RD_B;
            RAM_ren  <= 1'b1;
            RAM_addr <= base + PIX_STEP;
          end
        end

        ST_DONE: begin
          // Bus released to the next stage until the request is withdrawn
          RAM_addr <= '0;
          if (!in_valid) begin
            state     <= ST_IDLE;
            gray_done <= 1'b0;
            base      <= FIRST_BASE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_convert.sv
// +------------------------------------------------------------------+
// | Module   : tb_gray_convert                                        |
// | Brief    : Self-checking bench for gray_convert with a byte-RAM   |
// |            model and an image-level luma reference.               |
// |            Honours GRAY_ROUND_EN like the design.                 |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gray_convert;
  import gray_convert_pkg::*;

  localparam int HDR  = BMP_HEADER_SIZE;
  localparam int TOT  = BMP_TOTAL_SIZE;
  localparam int AW   = ADDR_WIDTH;
  localparam int NPIX = (TOT - HDR) / 3;

`ifdef GRAY_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    ram_q;
  logic          ram_ren;
  logic          ram_wen;
  logic [7:0]    ram_d;
  logic [AW-1:0] ram_addr;
  logic          gray_done;

  logic [7:0] mem      [TOT];
  logic [7:0] init_img [TOT];
  logic [7:0] golden   [TOT];
  logic       load;
  logic       quiet;
  int         both_cnt;
  int         quiet_cnt;
  int         chk_cnt;
  int         pass_cnt;
  int         fail_cnt;

  gray_convert #(
    .HEADER_SIZE (HDR),
    .TOTAL_SIZE  (TOT),
    .ADDR_W      (AW),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .RAM_Q     (ram_q),
    .RAM_ren   (ram_ren),
    .RAM_wen   (ram_wen),
    .RAM_D     (ram_d),
    .RAM_addr  (ram_addr),
    .gray_done (gray_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: registered read, synchronous write, bulk load from init_img
  always @(posedge clk) begin
    if (load) begin
      mem <= init_img;
    end else begin
      if (ram_ren && int'(ram_addr) < TOT) ram_q <= mem[int'(ram_addr)];
      if (ram_wen && int'(ram_addr) < TOT) mem[int'(ram_addr)] <= ram_d;
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    if (ram_ren && ram_wen) both_cnt <= both_cnt + 1;
    if (quiet && (ram_ren || ram_wen)) quiet_cnt <= quiet_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_luma(input int b, input int g, input int r);
    int s;
    s = 77 * r + 150 * g + 29 * b + RND * 128;
    return 8'(s / 256);
  endfunction

  task automatic set_px(input int p, input int b, input int g, input int r);
    init_img[HDR + 3*p]     = 8'(b);
    init_img[HDR + 3*p + 1] = 8'(g);
    init_img[HDR + 3*p + 2] = 8'(r);
  endtask

  task automatic random_image();
    for (int i = 0; i < TOT; i++) init_img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic snapshot();
    for (int i = 0; i < TOT; i++) init_img[i] = mem[i];
  endtask

  task automatic load_ram();
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Golden image: every full triplet after the header becomes Y,Y,Y
  task automatic make_golden();
    logic [7:0] y;
    for (int i = 0; i < TOT; i++) golden[i] = init_img[i];
    for (int a = HDR; a + 2 <= TOT - 1; a += 3) begin
      y = ref_luma(init_img[a], init_img[a+1], init_img[a+2]);
      golden[a] = y; golden[a+1] = y; golden[a+2] = y;
    end
  endtask

  task automatic run_image(input bit drop_early);
    int cycles;
    bit seen;
    make_golden();
    load_ram();
    in_valid = 1'b1;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      cycles++;
      #1;
      if (drop_early && cycles == 5) in_valid = 1'b0;
      if (gray_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", cycles, 1 + 7 * NPIX);
    check("done_addr", 32'(ram_addr), 0);
    if (!drop_early) begin
      quiet = 1'b1;
      repeat (5) @(posedge clk);
      #1 quiet = 1'b0;
      check("done_held", 32'(gray_done), 1);
      check("no_strobe_in_done", quiet_cnt, 0);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("done_cleared", 32'(gray_done), 0);
    for (int i = 0; i < TOT; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(golden[i]));
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    both_cnt = 0; quiet_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; load = 1'b0; quiet = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ren", 32'(ram_ren), 0);
    check("rst_wen", 32'(ram_wen), 0);
    check("rst_d", 32'(ram_d), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_done", 32'(gray_done), 0);
    rst = 1'b0;

    // Idle with request low: bus stays silent
    quiet = 1'b1;
    repeat (8) @(posedge clk);
    #1 quiet = 1'b0;
    check("idle_quiet", quiet_cnt, 0);

    // Directed corner pixels
    random_image();
    set_px(0, 0, 0, 255);
    set_px(1, 255, 255, 255);
    set_px(2, 0, 0, 0);
    set_px(3, 255, 0, 0);
    run_image(1'b0);
    check("red_only", 32'(mem[HDR]), 76 + RND);
    check("red_only_r", 32'(mem[HDR+2]), 76 + RND);
    check("white", 32'(mem[HDR+3]), 255);
    check("black", 32'(mem[HDR+6]), 0);
    check("blue_only", 32'(mem[HDR+9]), 28 + RND);

    random_image();
    set_px(0, 0, 255, 0);
    set_px(1, 10, 20, 30);
    run_image(1'b0);
    check("green_only", 32'(mem[HDR]), 149);
    check("mix_10_20_30", 32'(mem[HDR+3]), 21 + RND);

    // Reassert after DONE: full reconversion of the already-gray image
    snapshot();
    run_image(1'b0);

    // Reset during WR_G of pixel 2
    random_image();
    make_golden();
    load_ram();
    in_valid = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_wen", 32'(ram_wen), 1);
    check("pre_rst_addr", 32'(ram_addr), HDR + 4);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_ren", 32'(ram_ren), 0);
    check("mid_rst_wen", 32'(ram_wen), 0);
    check("mid_rst_d", 32'(ram_d), 0);
    check("mid_rst_addr", 32'(ram_addr), 0);
    check("mid_rst_done", 32'(gray_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("px2_b_written", 32'(mem[HDR+3]), 32'(golden[HDR+3]));
    check("px2_g_untouched", 32'(mem[HDR+4]), 32'(init_img[HDR+4]));
    snapshot();
    run_image(1'b0);
    check("px2_consistent_g", 32'(mem[HDR+4]), 32'(mem[HDR+3]));
    check("px2_consistent_r", 32'(mem[HDR+5]), 32'(mem[HDR+3]));

    // Random images, one with the request dropped mid-conversion
    for (int k = 0; k < 3; k++) begin
      random_image();
      run_image(k == 1);
    end

    check("ren_wen_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
